// File: rtl/spi_bridge_pkg.sv
// Shared types and helpers for the SPI-to-register-bus bridge.
package spi_bridge_pkg;

  localparam int K_DWIDTH_DEF = 16;
  localparam int K_AWIDTH_DEF = 7;
  localparam int K_RNW_BIT    = K_DWIDTH_DEF - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_LOAD,
    S_RD_STREAM,
    S_WR_STREAM,
    S_WR_REQ,
    S_DRAIN
  } state_e;

  // Start-address field of a command word (low awidth bits).
  function automatic logic [63:0] addr_field(input logic [63:0] word, input int awidth);
    return word & ((64'd1 << awidth) - 64'd1);
  endfunction

endpackage

// File: rtl/spi_reg_bridge.sv
// Converts SPI slave words into register-bus reads/writes with auto-incrementing
// address; read data is prefetched and handed back to the slave transmitter.
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int K_DWIDTH = K_DWIDTH_DEF,
  parameter int K_AWIDTH = K_AWIDTH_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [K_DWIDTH-1:0] i_rx_data,
  input  logic                i_rx_event,
  input  logic                i_txe,
  input  logic                i_selected,
  output logic [K_DWIDTH-1:0] o_tx_data,
  output logic                o_tx_valid,
  output logic [K_AWIDTH-1:0] o_reg_addr,
  output logic [K_DWIDTH-1:0] o_reg_wdata,
  output logic                o_reg_we,
  output logic                o_reg_re,
  input  logic [K_DWIDTH-1:0] i_reg_rdata,
  input  logic                i_reg_ack,
  output logic                o_overrun,
  output logic                o_busy
);

  state_e              r_state;
  logic [K_AWIDTH-1:0] r_addr;
  logic                w_ev;
  logic                w_rnw;
  logic [K_AWIDTH-1:0] w_cmd_addr;
  logic                w_unused_txe;

  assign w_ev         = i_rx_event & i_selected;
  assign w_rnw        = i_rx_data[K_DWIDTH-1];
  assign w_cmd_addr   = K_AWIDTH'(addr_field(64'(i_rx_data), K_AWIDTH));
  assign w_unused_txe = i_txe;

  // The load strobe is gated by chip-select so a deselect during RD_LOAD suppresses it.
  assign o_tx_valid = (r_state == S_RD_LOAD) && i_selected;
  assign o_busy     = (r_state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      o_tx_data   <= '0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
      o_reg_we    <= 1'b0;
      o_reg_re    <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ev) begin
            r_addr <= w_cmd_addr;
            if (w_rnw) begin
              o_reg_addr <= w_cmd_addr;
              o_reg_re   <= 1'b1;
              r_state    <= S_RD_REQ;
            end else begin
              r_state <= S_WR_STREAM;
            end
          end
        end
        S_RD_REQ: begin
          o_overrun <= w_ev;
          if (i_reg_ack) begin
            o_reg_re <= 1'b0;
            if (i_selected) begin
              o_tx_data <= i_reg_rdata;
              r_state   <= S_RD_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (!i_selected) begin
            r_state <= S_DRAIN;
          end
        end
        S_RD_LOAD: begin
          o_overrun <= w_ev;
          r_addr    <= r_addr + K_AWIDTH'(1);
          r_state   <= i_selected ? S_RD_STREAM : S_IDLE;
        end
        S_RD_STREAM: begin
          if (!i_selected) begin
            r_state <= S_IDLE;
          end else if (w_ev) begin
            o_reg_addr <= r_addr;
            o_reg_re   <= 1'b1;
            r_state    <= S_RD_REQ;
          end
        end
        S_WR_STREAM: begin
          if (!i_selected) begin
            r_state <= S_IDLE;
          end else if (w_ev) begin
            o_reg_addr  <= r_addr;
            o_reg_wdata <= i_rx_data;
            o_reg_we    <= 1'b1;
            r_state     <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          o_overrun <= w_ev;
          if (i_reg_ack) begin
            o_reg_we <= 1'b0;
            r_addr   <= r_addr + K_AWIDTH'(1);
            r_state  <= i_selected ? S_WR_STREAM : S_IDLE;
          end else if (!i_selected) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Whichever request was pending stays asserted until the bus completes it.
          if (i_reg_ack) begin
            o_reg_re <= 1'b0;
            o_reg_we <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
Sits directly downstream of the SPI slave. It turns received SPI words into register-bus transactions, and feeds read data back to the slave's transmit input. The first word of each chip-select frame is a command word (read/write flag plus start address). Every following word is either write data or a read clock-out slot, and the address auto-increments per word.

Parameters:
K_DWIDTH, 16, SPI word width and register data width
K_AWIDTH, 7, register address width; must be <= K_DWIDTH-1

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_rx_data  in  K_DWIDTH  received word from SPI slave
i_rx_event  in  1  single-cycle pulse, i_rx_data valid
i_txe  in  1  slave transmit buffer empty (1 = empty)
i_selected  in  1  registered chip-select active from slave
o_tx_data  out  K_DWIDTH  word to load into slave shifter
o_tx_valid  out  1  single-cycle load strobe for o_tx_data
o_reg_addr  out  K_AWIDTH  register address
o_reg_wdata  out  K_DWIDTH  register write data
o_reg_we  out  1  write request, held until i_reg_ack
o_reg_re  out  1  read request, held until i_reg_ack
i_reg_rdata  in  K_DWIDTH  read data, valid with i_reg_ack on a read
i_reg_ack  in  1  single-cycle transaction completion
o_overrun  out  1  single-cycle pulse: word received while a bus transaction was pending
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, i_rst_n low): state IDLE; all outputs 0; internal address 0.
- Command word format: bit K_DWIDTH-1 = RnW (1 = read); bits K_AWIDTH-1:0 = start address; other bits ignored.
- States: IDLE, RD_REQ, RD_LOAD, RD_STREAM, WR_STREAM, WR_REQ, DRAIN.
- IDLE:
  - i_rx_event & i_selected latches the address from the command word.
  - RnW=1 -> RD_REQ. RnW=0 -> WR_STREAM.
- RD_REQ:
  - o_reg_re=1 and o_reg_addr = current address, held until i_reg_ack.
  - On the ack cycle, capture i_reg_rdata into the tx register -> RD_LOAD.
- RD_LOAD: o_tx_valid=1 for exactly one cycle with o_tx_data = captured data; address += 1 -> RD_STREAM.
- RD_STREAM: each i_rx_event (received word is dummy, discarded) -> RD_REQ, to prefetch the next word.
- Read latency:
  - Cycles from rx_event to o_tx_valid = 2 + ack latency (ack latency 0 = ack the cycle after request).
  - The bus must respond within one SPI word time; otherwise the master clocks out stale/zero data. No recovery is provided.
- WR_STREAM: i_rx_event -> latch o_reg_wdata = i_rx_data, o_reg_addr = address -> WR_REQ.
- WR_REQ: o_reg_we=1 until i_reg_ack. On ack: address += 1 -> WR_STREAM.
- Address increment wraps modulo 2^K_AWIDTH (0x7F -> 0x00).
- Overrun:
  - i_rx_event while in RD_REQ, RD_LOAD or WR_REQ pulses o_overrun for one cycle.
  - The word is dropped; the pending transaction completes normally.
- Deselect (i_selected falls):
  - From IDLE/RD_STREAM/WR_STREAM: next cycle -> IDLE.
  - From RD_REQ/WR_REQ: request stays held -> DRAIN; on i_reg_ack -> IDLE. Read data is discarded, no o_tx_valid.
  - From RD_LOAD: suppress o_tx_valid -> IDLE.
- i_rx_event with i_selected low: ignored.
- Simultaneous i_rx_event and deselect in the same cycle: the event is processed, then the deselect rule applies on the next cycle.
- Request outputs never drop before ack; o_reg_re and o_reg_we are never both 1.
- i_txe is informational only: o_tx_valid is issued regardless of it.

Decomposition:
- spi_bridge_pkg holds:
  - state enum typedef
  - localparam for the RnW bit index (K_DWIDTH-1)
  - address field slice helper function
- Single flat module; no sub-module is warranted (FSM plus three registers).

Test Plan:
- Write burst: frame {0x0005, 0xA1A1, 0xB2B2}, ack latency 1 -> WE at addr 0x05 data 0xA1A1, then addr 0x06 data 0xB2B2; no o_overrun.
- Read burst: frame {0x8010, dummy, dummy}, rdata = addr+0x1000 -> RE addr 0x10, o_tx_valid data 0x1010; next prefetch addr 0x11, o_tx_valid data 0x1011.
- Wrap: write command 0x007F followed by two data words -> writes at 0x7F then 0x00.
- Overrun: write frame with ack held 40 cycles and next i_rx_event at cycle 10 -> o_overrun pulses once, one write only, next write uses addr+1.
- Deselect mid-read: i_selected drops during RD_REQ, ack 3 cycles later -> RE held until ack, no o_tx_valid, state IDLE one cycle after ack.
- Async reset asserted in WR_REQ -> all outputs 0 immediately; next frame's first word is treated as a command.
